// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 microsequencer.
// Contents:
//   - the state encoding, which uses the LC-3 state numbers;
//   - the opcode constants;
//   - the mux and ALU select encodings that processing_unit also uses;
//   - the packed control word produced by control_decode;
//   - the opcode-to-first-execute-state helper.
package lc3_ctrl_pkg;

   localparam int CU_STATE_W = 6;

   typedef enum logic [CU_STATE_W-1:0] {
      S0  = 6'd0,  S1  = 6'd1,  S2  = 6'd2,  S3  = 6'd3,
      S5  = 6'd5,  S9  = 6'd9,  S12 = 6'd12, S14 = 6'd14,
      S16 = 6'd16, S18 = 6'd18, S22 = 6'd22, S23 = 6'd23,
      S25 = 6'd25, S27 = 6'd27, S32 = 6'd32, S33 = 6'd33,
      S35 = 6'd35, S63 = 6'd63
   } state_e;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   localparam logic [1:0] ALUK_ADD   = 2'b00;
   localparam logic [1:0] ALUK_AND   = 2'b01;
   localparam logic [1:0] ALUK_NOT   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   localparam logic [1:0] SR1_IR11_9 = 2'b00;
   localparam logic [1:0] SR1_IR8_6  = 2'b01;
   localparam logic [1:0] SR1_R6     = 2'b10;

   localparam logic [1:0] DR_IR11_9  = 2'b00;
   localparam logic [1:0] DR_R6      = 2'b01;
   localparam logic [1:0] DR_R7      = 2'b10;

   localparam logic [1:0] PC_PLUS1   = 2'b00;
   localparam logic [1:0] PC_BUS     = 2'b01;
   localparam logic [1:0] PC_ADDER   = 2'b10;

   localparam logic       A1_PC      = 1'b0;
   localparam logic       A1_SR1     = 1'b1;

   localparam logic [1:0] A2_ZERO    = 2'b00;
   localparam logic [1:0] A2_OFF6    = 2'b01;
   localparam logic [1:0] A2_OFF9    = 2'b10;
   localparam logic [1:0] A2_OFF11   = 2'b11;

   localparam logic       MARMUX_ZEXT  = 1'b0;
   localparam logic       MARMUX_ADDER = 1'b1;

   localparam logic       RW_READ    = 1'b0;
   localparam logic       RW_WRITE   = 1'b1;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_pc;
      logic       ld_reg;
      logic       ld_cc;
      logic       ld_ben;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] aluk;
      logic [1:0] sr1mux;
      logic [1:0] drmux;
      logic [1:0] pcmux;
      logic       addr1mux;
      logic [1:0] addr2mux;
      logic       marmux;
      logic       mio_en;
      logic       r_w;
   } ctrl_t;

   localparam int    CTRL_W    = $bits(ctrl_t);
   localparam ctrl_t CTRL_IDLE = ctrl_t'({CTRL_W{1'b0}});

   // First execute state for an opcode; anything unsupported goes to halt_s.
   function automatic state_e op_to_state(input logic [3:0] op, input state_e halt_s);
      state_e s;
      case (op)
         OP_BR:   s = S0;
         OP_ADD:  s = S1;
         OP_AND:  s = S5;
         OP_NOT:  s = S9;
         OP_JMP:  s = S12;
         OP_LD:   s = S2;
         OP_ST:   s = S3;
         OP_LEA:  s = S14;
         default: s = halt_s;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational decode of microsequencer state into the datapath control word.
// Ports:
//   state     - current microsequencer state
//   mem_ready - memory ready; qualifies LD_MDR so MDR loads only when the read completes
//   ctrl      - control word; every control not named for a state stays 0
module control_decode
   import lc3_ctrl_pkg::*;
(
   input  state_e state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   // State to control word; at most one bus gate is driven in any state.
   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         S18: begin
            ctrl.gate_pc = 1'b1;
            ctrl.ld_mar  = 1'b1;
            ctrl.pcmux   = PC_PLUS1;
            ctrl.ld_pc   = 1'b1;
         end
         S33, S25: begin
            ctrl.mio_en = 1'b1;
            ctrl.r_w    = RW_READ;
            ctrl.ld_mdr = mem_ready;
         end
         S35: begin
            ctrl.gate_mdr = 1'b1;
            ctrl.ld_ir    = 1'b1;
         end
         S32: begin
            ctrl.ld_ben = 1'b1;
         end
         S1, S5, S9: begin
            ctrl.sr1mux   = SR1_IR8_6;
            ctrl.drmux    = DR_IR11_9;
            ctrl.gate_alu = 1'b1;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
            if (state == S1) begin
               ctrl.aluk = ALUK_ADD;
            end else if (state == S5) begin
               ctrl.aluk = ALUK_AND;
            end else begin
               ctrl.aluk = ALUK_NOT;
            end
         end
         S22: begin
            ctrl.addr1mux = A1_PC;
            ctrl.addr2mux = A2_OFF9;
            ctrl.pcmux    = PC_ADDER;
            ctrl.ld_pc    = 1'b1;
         end
         S12: begin
            ctrl.sr1mux   = SR1_IR8_6;
            ctrl.addr1mux = A1_SR1;
            ctrl.addr2mux = A2_ZERO;
            ctrl.pcmux    = PC_ADDER;
            ctrl.ld_pc    = 1'b1;
         end
         S14: begin
            ctrl.addr1mux    = A1_PC;
            ctrl.addr2mux    = A2_OFF9;
            ctrl.marmux      = MARMUX_ADDER;
            ctrl.gate_marmux = 1'b1;
            ctrl.drmux       = DR_IR11_9;
            ctrl.ld_reg      = 1'b1;
         end
         S2, S3: begin
            ctrl.addr1mux    = A1_PC;
            ctrl.addr2mux    = A2_OFF9;
            ctrl.marmux      = MARMUX_ADDER;
            ctrl.gate_marmux = 1'b1;
            ctrl.ld_mar      = 1'b1;
         end
         S27: begin
            ctrl.gate_mdr = 1'b1;
            ctrl.drmux    = DR_IR11_9;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
         end
         S23: begin
            ctrl.sr1mux   = SR1_IR11_9;
            ctrl.aluk     = ALUK_PASSA;
            ctrl.gate_alu = 1'b1;
            ctrl.ld_mdr   = 1'b1;
         end
         S16: begin
            ctrl.mio_en = 1'b1;
            ctrl.r_w    = RW_WRITE;
         end
         default: begin
            ctrl = CTRL_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// LC-3 microsequencer (Moore FSM).
// It covers fetch, decode, ADD, AND, NOT, BR, JMP, LD, ST and LEA.
// Ports:
//   i_CLK, i_RST        - clock; synchronous active-high reset into fetch (state 18)
//   i_IR                - instruction register; only the opcode steers sequencing
//   i_BEN               - latched branch enable from the datapath
//   i_R                 - memory ready; low holds the memory states
//   o_LD_* / o_Gate*    - register loads and bus drivers
//   o_ALUK, o_*MUX      - datapath selects (encodings in lc3_ctrl_pkg)
//   o_MIO_EN, o_R_W     - memory access enable and direction
//   o_HALT              - high while parked in the halt state
//   o_STATE             - current state number
// All controls are forced to 0 while i_RST is high, so an interrupted access is dropped
// immediately rather than completing on the reset cycle.
module control_unit
   import lc3_ctrl_pkg::*;
#(
   parameter int STATE_W    = 6,
   parameter int HALT_STATE = 63
)(
   input  logic               i_CLK,
   input  logic               i_RST,
   input  logic [15:0]        i_IR,
   input  logic               i_BEN,
   input  logic               i_R,
   output logic               o_LD_MAR,
   output logic               o_LD_MDR,
   output logic               o_LD_IR,
   output logic               o_LD_PC,
   output logic               o_LD_REG,
   output logic               o_LD_CC,
   output logic               o_LD_BEN,
   output logic               o_GatePC,
   output logic               o_GateMDR,
   output logic               o_GateALU,
   output logic               o_GateMARMUX,
   output logic [1:0]         o_ALUK,
   output logic [1:0]         o_SR1MUX,
   output logic [1:0]         o_DRMUX,
   output logic [1:0]         o_PCMUX,
   output logic               o_ADDR1MUX,
   output logic [1:0]         o_ADDR2MUX,
   output logic               o_MARMUX,
   output logic               o_MIO_EN,
   output logic               o_R_W,
   output logic               o_HALT,
   output logic [STATE_W-1:0] o_STATE
);

   localparam state_e HALT_S = state_e'(CU_STATE_W'(HALT_STATE));

   state_e state_r;
   state_e next_state_s;
   ctrl_t  ctrl_s;
   ctrl_t  out_s;

   // Operand fields are decoded in the datapath, not here.
   logic   ir_unused_s;
   assign ir_unused_s = ^i_IR[11:0];

   // State register with synchronous reset into fetch.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_r <= S18;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state sequencing; memory states hold until ready, unknown codes park in halt.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S18: next_state_s = S33;
         S33: begin
            if (i_R) begin
               next_state_s = S35;
            end else begin
               next_state_s = S33;
            end
         end
         S35: next_state_s = S32;
         S32: next_state_s = op_to_state(i_IR[15:12], HALT_S);
         S0: begin
            if (i_BEN) begin
               next_state_s = S22;
            end else begin
               next_state_s = S18;
            end
         end
         S1, S5, S9, S12, S14, S22, S27: next_state_s = S18;
         S2:  next_state_s = S25;
         S25: begin
            if (i_R) begin
               next_state_s = S27;
            end else begin
               next_state_s = S25;
            end
         end
         S3:  next_state_s = S23;
         S23: next_state_s = S16;
         S16: begin
            if (i_R) begin
               next_state_s = S18;
            end else begin
               next_state_s = S16;
            end
         end
         default: next_state_s = HALT_S;
      endcase
   end

   control_decode u_decode (
      .state     (state_r),
      .mem_ready (i_R),
      .ctrl      (ctrl_s)
   );

   // Reset silences every control, including a memory access caught mid-wait.
   always_comb begin
      if (i_RST) begin
         out_s = CTRL_IDLE;
      end else begin
         out_s = ctrl_s;
      end
   end

   assign o_LD_MAR     = out_s.ld_mar;
   assign o_LD_MDR     = out_s.ld_mdr;
   assign o_LD_IR      = out_s.ld_ir;
   assign o_LD_PC      = out_s.ld_pc;
   assign o_LD_REG     = out_s.ld_reg;
   assign o_LD_CC      = out_s.ld_cc;
   assign o_LD_BEN     = out_s.ld_ben;
   assign o_GatePC     = out_s.gate_pc;
   assign o_GateMDR    = out_s.gate_mdr;
   assign o_GateALU    = out_s.gate_alu;
   assign o_GateMARMUX = out_s.gate_marmux;
   assign o_ALUK       = out_s.aluk;
   assign o_SR1MUX     = out_s.sr1mux;
   assign o_DRMUX      = out_s.drmux;
   assign o_PCMUX      = out_s.pcmux;
   assign o_ADDR1MUX   = out_s.addr1mux;
   assign o_ADDR2MUX   = out_s.addr2mux;
   assign o_MARMUX     = out_s.marmux;
   assign o_MIO_EN     = out_s.mio_en;
   assign o_R_W        = out_s.r_w;
   assign o_HALT       = !i_RST && (state_r == HALT_S);
   assign o_STATE      = STATE_W'(state_r);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit.
// The reference model is an instruction-level plan: at fetch it builds the list of
// microsteps for the instruction and walks that list.  Memory steps wait on i_R,
// and a branch is resolved by i_BEN.  Expected controls come from each step's role.
module tb_control_unit;

   logic        i_CLK = 1'b0;
   logic        i_RST, i_BEN, i_R;
   logic [15:0] i_IR;
   logic        o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG, o_LD_CC, o_LD_BEN;
   logic        o_GatePC, o_GateMDR, o_GateALU, o_GateMARMUX;
   logic [1:0]  o_ALUK, o_SR1MUX, o_DRMUX, o_PCMUX, o_ADDR2MUX;
   logic        o_ADDR1MUX, o_MARMUX, o_MIO_EN, o_R_W, o_HALT;
   logic [5:0]  o_STATE;

   always #5 i_CLK = ~i_CLK;

   control_unit dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_IR(i_IR), .i_BEN(i_BEN), .i_R(i_R),
      .o_LD_MAR(o_LD_MAR), .o_LD_MDR(o_LD_MDR), .o_LD_IR(o_LD_IR), .o_LD_PC(o_LD_PC),
      .o_LD_REG(o_LD_REG), .o_LD_CC(o_LD_CC), .o_LD_BEN(o_LD_BEN),
      .o_GatePC(o_GatePC), .o_GateMDR(o_GateMDR), .o_GateALU(o_GateALU),
      .o_GateMARMUX(o_GateMARMUX), .o_ALUK(o_ALUK), .o_SR1MUX(o_SR1MUX),
      .o_DRMUX(o_DRMUX), .o_PCMUX(o_PCMUX), .o_ADDR1MUX(o_ADDR1MUX),
      .o_ADDR2MUX(o_ADDR2MUX), .o_MARMUX(o_MARMUX), .o_MIO_EN(o_MIO_EN),
      .o_R_W(o_R_W), .o_HALT(o_HALT), .o_STATE(o_STATE)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: the step being presented now, and the steps still to come.
   int exp_state = -1;
   int plan[$];

   int          seen_state[$];
   logic [25:0] seen_word[$];

   // Bit positions in the packed 26-bit control word.
   localparam int B_LD_MDR = 24, B_LD_REG = 21, B_LD_CC = 20, B_GALU = 16;
   localparam int B_MIO = 2, B_RW = 1, B_HALT = 0;

   function automatic logic [25:0] dut_word();
      return {o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG, o_LD_CC, o_LD_BEN,
              o_GatePC, o_GateMDR, o_GateALU, o_GateMARMUX, o_ALUK, o_SR1MUX,
              o_DRMUX, o_PCMUX, o_ADDR1MUX, o_ADDR2MUX, o_MARMUX, o_MIO_EN,
              o_R_W, o_HALT};
   endfunction

   // Expected controls for the step currently presented.
   function automatic logic [25:0] exp_word(input int st, input bit r, input bit rst);
      bit ld_mar = 0, ld_mdr = 0, ld_ir = 0, ld_pc = 0, ld_reg = 0, ld_cc = 0, ld_ben = 0;
      bit g_pc = 0, g_mdr = 0, g_alu = 0, g_mm = 0;
      bit [1:0] aluk = 0, sr1 = 0, dr = 0, pcm = 0, a2 = 0;
      bit a1 = 0, mm = 0, mio = 0, rw = 0, halt = 0;
      if (!rst) begin
         case (st)
            18: begin g_pc = 1; ld_mar = 1; ld_pc = 1; end              // PC -> MAR, PC+1
            33, 25: begin mio = 1; ld_mdr = r; end                       // memory read
            35: begin g_mdr = 1; ld_ir = 1; end                          // MDR -> IR
            32: ld_ben = 1;
            1, 5, 9: begin                                               // ALU op writeback
               sr1 = 2'b01; g_alu = 1; ld_reg = 1; ld_cc = 1;
               aluk = (st == 1) ? 2'b00 : ((st == 5) ? 2'b01 : 2'b10);
            end
            22: begin a2 = 2'b10; pcm = 2'b10; ld_pc = 1; end           // PC + off9
            12: begin sr1 = 2'b01; a1 = 1; pcm = 2'b10; ld_pc = 1; end   // PC <- BaseR
            14: begin a2 = 2'b10; mm = 1; g_mm = 1; ld_reg = 1; end      // DR <- PC+off9
            2, 3: begin a2 = 2'b10; mm = 1; g_mm = 1; ld_mar = 1; end    // MAR <- PC+off9
            27: begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end              // DR <- MDR
            23: begin aluk = 2'b11; g_alu = 1; ld_mdr = 1; end           // MDR <- SR
            16: begin mio = 1; rw = 1; end                               // memory write
            63: halt = 1;
            default: ;
         endcase
      end
      return {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben, g_pc, g_mdr, g_alu, g_mm,
              aluk, sr1, dr, pcm, a1, a2, mm, mio, rw, halt};
   endfunction

   // Microsteps of one whole instruction, starting with the fetch read.
   function automatic void build_plan(input logic [15:0] ir);
      plan = '{33, 35, 32};
      case (ir[15:12])
         4'd1:  plan.push_back(1);
         4'd5:  plan.push_back(5);
         4'd9:  plan.push_back(9);
         4'd0:  plan.push_back(0);
         4'd12: plan.push_back(12);
         4'd14: plan.push_back(14);
         4'd2:  begin plan.push_back(2); plan.push_back(25); plan.push_back(27); end
         4'd3:  begin plan.push_back(3); plan.push_back(23); plan.push_back(16); end
         default: plan.push_back(63);
      endcase
   endfunction

   function automatic void advance(input bit rs, input bit r, input bit ben, input logic [15:0] ir);
      if (rs) begin
         exp_state = 18;
         plan.delete();
      end else if (exp_state == 63) begin
         exp_state = 63;
      end else if ((exp_state == 33 || exp_state == 25 || exp_state == 16) && !r) begin
         exp_state = exp_state;
      end else if (exp_state == 18) begin
         build_plan(ir);
         exp_state = plan.pop_front();
      end else if (exp_state == 0) begin
         exp_state = ben ? 22 : 18;
      end else if (plan.size() > 0) begin
         exp_state = plan.pop_front();
      end else begin
         exp_state = 18;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, compare against the model, advance at posedge.
   task automatic apply(input bit rs, input bit rr, input bit bb, input logic [15:0] ii);
      logic [25:0] w;
      int gates;
      @(negedge i_CLK);
      i_RST = rs; i_R = rr; i_BEN = bb; i_IR = ii;
      #1;
      w = dut_word();
      chk("ctrl_word", 32'(w), 32'(exp_word(exp_state, rr, rs)));
      if (exp_state >= 0) chk("state", 32'(o_STATE), 32'(exp_state));
      gates = int'(o_GatePC) + int'(o_GateMDR) + int'(o_GateALU) + int'(o_GateMARMUX);
      chk("bus_gate_excl", 32'(gates > 1), 32'd0);
      seen_state.push_back(int'(o_STATE));
      seen_word.push_back(w);
      @(posedge i_CLK);
      advance(rs, rr, bb, ii);
   endtask

   // Run one instruction from fetch; i_R is low for hold_n cycles in state hold_st.
   task automatic run_instr(input logic [15:0] ir, input bit bb, input int hold_st, input int hold_n);
      int holds = 0;
      int cyc = 0;
      bit rr;
      seen_state.delete();
      seen_word.delete();
      do begin
         rr = 1'b1;
         if (exp_state == hold_st && holds < hold_n) begin
            rr = 1'b0;
            holds++;
         end
         apply(1'b0, rr, bb, ir);
         cyc++;
      end while (exp_state != 18 && exp_state != 63 && cyc < 40);
      chk("instr_within_budget", 32'(cyc < 40), 32'd1);
   endtask

   function automatic int idx_of(input int st);
      foreach (seen_state[i]) if (seen_state[i] == st) return i;
      return 0;
   endfunction

   function automatic int count_state(input int st);
      int n = 0;
      foreach (seen_state[i]) if (seen_state[i] == st) n++;
      return n;
   endfunction

   task automatic chk_seq(input string name, input int exp_seq[$]);
      chk({name, "_len"}, 32'(seen_state.size()), 32'(exp_seq.size()));
      foreach (exp_seq[i]) begin
         if (i < seen_state.size()) chk(name, 32'(seen_state[i]), 32'(exp_seq[i]));
      end
   endtask

   logic [3:0]  ops[8] = '{4'd0, 4'd1, 4'd5, 4'd9, 4'd12, 4'd2, 4'd3, 4'd14};
   logic [15:0] cur_ir;
   logic [25:0] w;
   bit          cur_ben, rs, rr;
   int          halt_cyc, n_mdr, n_ok;

   initial begin
      i_RST = 1'b1; i_R = 1'b0; i_BEN = 1'b0; i_IR = 16'h0000;
      apply(1'b1, 1'b0, 1'b0, 16'h0000);
      apply(1'b1, 1'b0, 1'b0, 16'h0000);

      // 1: reset while waiting on memory in state 33
      seen_state.delete();
      seen_word.delete();
      apply(1'b0, 1'b1, 1'b0, 16'h12A3);
      apply(1'b0, 1'b0, 1'b0, 16'h12A3);
      apply(1'b0, 1'b0, 1'b0, 16'h12A3);
      apply(1'b1, 1'b0, 1'b0, 16'h12A3);
      w = seen_word[2];
      chk("t1_mio_before_rst", 32'(w[B_MIO]), 32'd1);
      w = seen_word[3];
      chk("t1_mio_in_rst", 32'(w[B_MIO]), 32'd0);
      chk("t1_all_zero_in_rst", 32'(w), 32'd0);
      #1;
      chk("t1_state_after_rst", 32'(o_STATE), 32'd18);

      // 2: ADD R1,R2,#3
      run_instr(16'h12A3, 1'b0, -1, 0);
      chk_seq("t2_seq", '{18, 33, 35, 32, 1});
      w = seen_word[idx_of(1)];
      chk("t2_aluk", 32'(w[14:13]), 32'd0);
      chk("t2_sr1mux", 32'(w[12:11]), 32'd1);
      chk("t2_drmux", 32'(w[10:9]), 32'd0);
      chk("t2_ldreg_ldcc_galu", 32'({w[B_LD_REG], w[B_LD_CC], w[B_GALU]}), 32'd7);

      // 3: BRz taken, then not taken
      run_instr(16'h0405, 1'b1, -1, 0);
      chk_seq("t3_taken_seq", '{18, 33, 35, 32, 0, 22});
      w = seen_word[idx_of(22)];
      chk("t3_pcmux", 32'(w[8:7]), 32'd2);
      chk("t3_addr2mux", 32'(w[5:4]), 32'd2);
      run_instr(16'h0405, 1'b0, -1, 0);
      chk_seq("t3_not_taken_seq", '{18, 33, 35, 32, 0});

      // 4: LD with three not-ready cycles in 25
      run_instr(16'h2002, 1'b0, 25, 3);
      chk("t4_cycles_in_25", 32'(count_state(25)), 32'd4);
      n_mdr = 0;
      foreach (seen_state[i]) if (seen_state[i] == 25) n_mdr += int'(seen_word[i][B_LD_MDR]);
      chk("t4_ld_mdr_count", 32'(n_mdr), 32'd1);
      w = seen_word[idx_of(25) + 3];
      chk("t4_ld_mdr_last", 32'(w[B_LD_MDR]), 32'd1);
      w = seen_word[idx_of(27)];
      chk("t4_27_ld_reg", 32'(w[B_LD_REG]), 32'd1);

      // 5: ST with two not-ready cycles in 16
      run_instr(16'h3003, 1'b0, 16, 2);
      w = seen_word[idx_of(23)];
      chk("t5_sr1mux", 32'(w[12:11]), 32'd0);
      chk("t5_aluk", 32'(w[14:13]), 32'd3);
      chk("t5_ld_mdr", 32'(w[B_LD_MDR]), 32'd1);
      n_ok = 0;
      foreach (seen_state[i]) if (seen_state[i] == 16 && seen_word[i][B_MIO] && seen_word[i][B_RW]) n_ok++;
      chk("t5_write_cycles", 32'(n_ok), 32'd3);

      // 6: unsupported opcode parks in halt
      run_instr(16'hF025, 1'b0, -1, 0);
      chk_seq("t6_seq", '{18, 33, 35, 32});
      seen_state.delete();
      seen_word.delete();
      for (int i = 0; i < 20; i++) apply(1'b0, 1'($urandom), 1'($urandom), 16'hF025);
      n_ok = 0;
      foreach (seen_word[i]) if (seen_word[i] == 26'd1 && seen_state[i] == 63) n_ok++;
      chk("t6_halt_cycles", 32'(n_ok), 32'd20);
      apply(1'b1, 1'b0, 1'b0, 16'hF025);
      #1;
      chk("t6_state_after_rst", 32'(o_STATE), 32'd18);

      // Randomized run against the model
      cur_ir = 16'h1000;
      cur_ben = 1'b0;
      halt_cyc = 0;
      seen_state.delete();
      seen_word.delete();
      for (int c = 0; c < 3000; c++) begin
         if (exp_state == 18) begin
            cur_ir = {($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)],
                      12'($urandom)};
            cur_ben = 1'($urandom);
         end
         halt_cyc = (exp_state == 63) ? halt_cyc + 1 : 0;
         rs = ($urandom_range(0, 99) == 0) || (halt_cyc > 6);
         rr = ($urandom_range(0, 9) < 7);
         apply(rs, rr, cur_ben, cur_ir);
         if (seen_state.size() > 64) begin
            seen_state.delete();
            seen_word.delete();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
